ifetch_ctrl: RTL
================

# ifetch_ctrl

Instruction-fetch controller that sits directly upstream of the 32-bit PC register and drives that register's clock-enable and data inputs. It reads the current PC from the register's Q output, issues one instruction-memory read per PC over a request/grant/response handshake, and holds the fetched word for decode until decode accepts it. It then advances the PC by 4, or loads a redirect target from branch/jump/exception logic.

## Interface
- FAULT_INST, 32'h0000_0000: instruction word presented on a misaligned-PC fault (NOP).
- PC_STEP, 4: sequential PC increment.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- pc_q  in  32  current PC, from the PC register Q.
- pc_ce  out  1  PC register clock-enable; one-cycle pulse.
- pc_d  out  32  next PC, to the PC register D; meaningful only when pc_ce=1.
- mem_req  out  1  instruction read request.
- mem_addr  out  32  read address; equals pc_q while mem_req=1.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; exactly one per granted request, earliest the cycle after mem_gnt.
- mem_rdata  in  32  read data.
- inst_valid  out  1  fetched instruction available.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of inst.
- inst_fault  out  1  inst came from a misaligned PC.
- inst_ready  in  1  decode accepts inst this cycle.
- redirect  in  1  load redirect_pc into the PC; single-cycle pulse.
- redirect_pc  in  32  redirect target.

## Operation
- States are IDLE, REQ, WAIT and OUT.
- Reset state is IDLE. Reset values: pc_ce=0, mem_req=0, inst_valid=0, inst_fault=0, inst=0, inst_pc=0, discard=0.
- IDLE -> REQ unconditionally, in the next cycle.
- REQ with pc_q[1:0]!=0:
  - No memory request is issued.
  - Latch inst=FAULT_INST, inst_fault=1, inst_pc=pc_q.
  - Go to OUT.
- REQ with pc_q aligned:
  - mem_req=1 and mem_addr=pc_q.
  - mem_req and mem_addr stay stable until mem_gnt; a request is never withdrawn.
  - On mem_gnt, go to WAIT.
- WAIT:
  - On mem_rvalid with discard=0: latch inst=mem_rdata, inst_pc=pc_q, inst_fault=0, then go to OUT.
  - On mem_rvalid with discard=1: drop the data, clear discard, then go to REQ.
- OUT:
  - inst_valid=1; inst, inst_pc and inst_fault stay stable until accepted.
  - On inst_ready: pc_ce=1 and pc_d=pc_q+PC_STEP (modulo 2^32, 32'hFFFF_FFFC wraps to 0). Go to REQ.
- Redirect, from any state except reset:
  - pc_ce=1 and pc_d=redirect_pc in that same cycle.
  - IDLE, or REQ without mem_gnt while misaligned: go to REQ.
  - REQ with an outstanding request: keep mem_req asserted, set discard, and go to WAIT on mem_gnt.
  - REQ with mem_gnt in the same cycle: set discard and go to WAIT.
  - WAIT: set discard. If mem_rvalid arrives in the same cycle, drop it and go to REQ with discard=0.
  - OUT: inst_valid drops the next cycle and the state goes to REQ. Redirect beats inst_ready, so no PC+4 occurs.
- Only one pc_ce pulse is allowed per cycle; pc_d selects redirect_pc over pc_q+PC_STEP.
- Reset mid-operation returns to IDLE with discard=0. An in-flight mem_rvalid after reset is ignored, because IDLE and REQ ignore mem_rvalid.

## Timing
- The PC register updates on the same edge that samples pc_ce. The REQ cycle after a pc_ce pulse therefore already sees the new pc_q.
- Best-case fetch:
  - cycle 0: REQ, mem_gnt.
  - cycle 1: WAIT, mem_rvalid.
  - cycle 2: OUT, inst_valid=1.
  - With inst_ready=1 in cycle 2, pc_ce pulses in cycle 2 and the next REQ is in cycle 3.
- Sustained throughput is 1 instruction per 3 cycles. There is no prefetch and at most one outstanding request.
- All outputs are registered except the following, which are combinational from state and inputs:
  - mem_req and mem_addr.
  - pc_ce and pc_d.
- inst_valid has no combinational path from inst_ready.

## Structure
- Shared package ifetch_pkg holds:
  - the state enum, with 2-bit encoding IDLE=0, REQ=1, WAIT=2, OUT=3;
  - PC_STEP;
  - FAULT_INST default.
- Sub-module ifetch_buf: 65-bit output holding register (inst, inst_pc, inst_fault) with load enable and synchronous clear. It is instantiated once.
- The FSM, discard flag and next-PC mux live in the top module.

## Test plan
- Reset, pc_q=0, memory with 0-cycle grant and 1-cycle rvalid returning 32'h2408_0001, inst_ready=1 -> mem_req with addr=0 in cycle 1. Then inst_valid with inst=32'h2408_0001 and inst_pc=0, pc_ce pulse with pc_d=4, and next request at addr=4.
- Grant delayed 3 cycles and inst_ready held low 5 cycles -> mem_addr stable during the wait, inst stable during the stall, and exactly one pc_ce.
- Redirect to 32'h0000_0100 while in WAIT -> stale rvalid data never appears on inst. Next mem_addr=32'h100.
- Redirect in the same cycle as inst_ready in OUT -> pc_d=redirect_pc, no PC+4, and inst_valid low the next cycle.
- pc_q=32'h0000_0102 -> no mem_req. inst_valid with inst_fault=1, inst=0 and inst_pc=32'h102.
- pc_q=32'hFFFF_FFFC accepted -> pc_d=0. rst asserted in WAIT followed by a late rvalid -> state IDLE, no inst_valid from the late data.

Source files
------------

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction-fetch controller
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] FAULT_INST = 32'h0000_0000;

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - instruction-memory request/grant/response bus
interface ifetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - 65-bit holding register for the fetched word, its PC and fault flag
module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        ld,
  input  logic [31:0] ld_inst,
  input  logic [31:0] ld_pc,
  input  logic        ld_fault,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  logic [64:0] q;

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= {ld_fault, ld_pc, ld_inst};
    end
  end

  assign inst       = q[31:0];
  assign inst_pc    = q[63:32];
  assign inst_fault = q[64];

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - fetch FSM: one memory read per PC, holds the word for decode, steps or redirects the PC
module ifetch_ctrl
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_q,
  output logic        pc_ce,
  output logic [31:0] pc_d,
  ifetch_if.master    mem,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  state_t      state, state_nxt;
  logic        discard, discard_nxt;
  logic [31:0] hold_addr;
  logic        hold_ld;
  logic        buf_ld;
  logic [31:0] buf_inst;
  logic        buf_fault;
  logic        misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      discard   <= 1'b0;
      hold_addr <= '0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
      if (hold_ld) hold_addr <= pc_q;
    end
  end

  // Once a redirect lands on an ungranted request, pc_q already points at the
  // new target, so the pending request keeps presenting the captured address.
  assign misaligned = (pc_q[1:0] != 2'b00) && !discard;

  always_comb begin
    state_nxt    = state;
    discard_nxt  = discard;
    hold_ld      = 1'b0;
    pc_ce        = 1'b0;
    pc_d         = pc_q + PC_STEP;
    mem.mem_req  = 1'b0;
    mem.mem_addr = discard ? hold_addr : pc_q;
    buf_ld       = 1'b0;
    buf_inst     = mem.mem_rdata;
    buf_fault    = 1'b0;

    if (!rst) begin
      if (redirect) begin
        pc_ce = 1'b1;
        pc_d  = redirect_pc;
      end
      case (state)
        IDLE: state_nxt = REQ;
        REQ: begin
          if (misaligned) begin
            if (!redirect) begin
              buf_ld    = 1'b1;
              buf_inst  = FAULT_INST;
              buf_fault = 1'b1;
              state_nxt = OUT;
            end
          end else begin
            mem.mem_req = 1'b1;
            if (redirect) begin
              discard_nxt = 1'b1;
              hold_ld     = !discard;
            end
            if (mem.mem_gnt) state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            if (discard || redirect) begin
              discard_nxt = 1'b0;
              state_nxt   = REQ;
            end else begin
              buf_ld    = 1'b1;
              state_nxt = OUT;
            end
          end else if (redirect) begin
            discard_nxt = 1'b1;
          end
        end
        OUT: begin
          // redirect wins over acceptance: no PC step alongside it
          if (redirect) begin
            state_nxt = REQ;
          end else if (inst_ready) begin
            pc_ce     = 1'b1;
            state_nxt = REQ;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign inst_valid = (state == OUT);

  ifetch_buf u_buf (
    .clk        (clk),
    .clr        (rst),
    .ld         (buf_ld),
    .ld_inst    (buf_inst),
    .ld_pc      (pc_q),
    .ld_fault   (buf_fault),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault)
  );

endmodule
